// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_pkg
//  Purpose  : Shared constants, loader state encoding and the element-offset
//             helper used by the MPU matrix loader and determinant stage.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mpu_pkg;

  localparam int unsigned N_MAX    = 5;
  localparam int unsigned W        = 8;
  localparam int unsigned ROW_BITS = N_MAX * W;
  localparam int unsigned MAT_BITS = N_MAX * N_MAX * W;

  // Largest order the loader accepts, as a signed size byte.
  localparam logic signed [7:0] SIZE_MAX = 8'sd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } loader_state_e;

  // Bit offset of element (r,c) in the packed operand bus. The result fits in
  // 8 bits (max 4*40 + 4*8 = 192), which is exactly the index width of a
  // 200-bit vector.
  function automatic logic [7:0] off(input logic [2:0] r, input logic [2:0] c);
    off = ({5'd0, r} * 8'(ROW_BITS)) + ({5'd0, c} * 8'(W));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_rc_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_rc_counter
//  Purpose  : Row-major row/column stepper bounded by the latched matrix order.
//             Flags the last element so the loader knows when to stop.
//  Ports    : clock, reset_n  - clock and asynchronous active-low reset
//             clr_i           - synchronous return to (0,0)
//             step_i          - advance one element (accepted beat)
//             size_i          - matrix order, 1..5
//             row_o, col_o    - current element position
//             last_o          - current position is (size-1,size-1)
//  Revision : 1.0  initial release
// ============================================================================
module mpu_rc_counter
  import mpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       step_i,
  input  logic [2:0] size_i,
  output logic [2:0] row_o,
  output logic [2:0] col_o,
  output logic       last_o
);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       col_end;

  assign col_end = (col_q == size_i - 3'd1);
  assign last_o  = col_end && (row_q == size_i - 3'd1);
  assign row_o   = row_q;
  assign col_o   = col_q;

  // The last element does not wrap: the counters park at (size-1,size-1)
  // until the loader clears them for the next operand.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = 3'd0;
      col_d = 3'd0;
    end else if (step_i && !last_o) begin
      if (col_end) begin
        col_d = 3'd0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= 3'd0;
      col_q <= 3'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mpu_matrix_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_matrix_loader
//  Purpose  : Accepts a matrix order and then order*order signed elements in
//             row-major order, assembles them into the packed 5x5 operand bus
//             and holds it with mat_valid until the determinant stage accepts.
//  Ports    : clock, reset_n           - clock, async active-low reset
//             flush                    - synchronous abort to IDLE
//             cfg_valid/cfg_size/cfg_ready, size_err - order offer channel
//             in_valid/in_data/in_ready              - element stream
//             matrix, size, mat_valid, mat_ready     - assembled operand
//  Revision : 1.0  initial release
// ============================================================================
module mpu_matrix_loader
  import mpu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  cfg_valid,
  input  logic signed [W-1:0]   cfg_size,
  output logic                  cfg_ready,
  output logic                  size_err,
  input  logic                  in_valid,
  input  logic signed [W-1:0]   in_data,
  output logic                  in_ready,
  output logic [0:MAT_BITS-1]   matrix,
  output logic signed [W-1:0]   size,
  output logic                  mat_valid,
  input  logic                  mat_ready
);

  loader_state_e         state_q;
  logic [0:MAT_BITS-1]   matrix_q;
  logic signed [W-1:0]   size_q;
  logic                  mat_valid_q;
  logic                  cfg_ready_q;
  logic                  in_ready_q;
  logic                  size_err_q;

  logic [2:0]            row;
  logic [2:0]            col;
  logic                  last;
  logic                  cfg_ok;
  logic                  cfg_accept;
  logic                  beat;

  assign cfg_ok     = (cfg_size > 8'sd0) && (cfg_size <= SIZE_MAX);
  assign cfg_accept = (state_q == IDLE) && cfg_valid && cfg_ready_q && cfg_ok;
  assign beat       = (state_q == LOAD) && in_valid && in_ready_q;

  mpu_rc_counter u_rc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (flush || cfg_accept),
    .step_i  (beat && !flush),
    .size_i  (size_q[2:0]),
    .row_o   (row),
    .col_o   (col),
    .last_o  (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      matrix_q    <= '0;
      size_q      <= '0;
      mat_valid_q <= 1'b0;
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      size_err_q  <= 1'b0;
    end else if (flush) begin
      // Abort wins over any handshake in the same cycle; partial data is lost.
      state_q     <= IDLE;
      matrix_q    <= '0;
      size_q      <= '0;
      mat_valid_q <= 1'b0;
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      size_err_q  <= 1'b0;
    end else begin
      size_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_valid && cfg_ready_q) begin
            if (cfg_ok) begin
              state_q     <= LOAD;
              size_q      <= cfg_size;
              matrix_q    <= '0;
              cfg_ready_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              size_err_q  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat) begin
            matrix_q[off(row, col) +: W] <= in_data;
            if (last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              mat_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Operand and size stay in place after release; only a new cfg or
          // flush clears them.
          if (mat_ready) begin
            state_q     <= IDLE;
            mat_valid_q <= 1'b0;
            cfg_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          mat_valid_q <= 1'b0;
          cfg_ready_q <= 1'b1;
          in_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign matrix    = matrix_q;
  assign size      = size_q;
  assign mat_valid = mat_valid_q;
  assign cfg_ready = cfg_ready_q;
  assign in_ready  = in_ready_q;
  assign size_err  = size_err_q;

endmodule
`default_nettype wire
